// File: rtl/sprite_physics_mover.sv
// sprite_physics_mover
// Per-sprite motion engine: GROUND/CLIMB/JUMP/FALL state machine, signed
// fixed-point velocity, gravity with a terminal fall speed, and collision
// flags latched across a frame. Everything moves once per startOfFrame.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   startOfFrame          one-cycle pulse per frame
//   move_left/right/up/down, jump   key levels
//   collision_with_ground, collision_with_rope, HitEdgeCode[3:0]
//                         per-pixel hits; HitEdgeCode = {left, top, right, bottom}
//   topLeftX, topLeftY    signed pixel position (floor of the fixed-point value)
//   motion_state          GROUND=0, CLIMB=1, JUMP=2, FALL=3 (also the debug view)
//   landed                one-cycle pulse on FALL -> GROUND
//
// Optional build macro: COYOTE_TIME_EN
//   When defined, a jump pressed within COYOTE_FRAMES frames of walking off
//   a ledge still takes off. When undefined, jump is ignored while falling.
module sprite_physics_mover #(
  parameter int INITIAL_X     = 280,
  parameter int INITIAL_Y     = 185,
  parameter int POS_W         = 11,
  parameter int FRAC_BITS     = 6,
  parameter int WALK_SPEED    = 30,
  parameter int AIR_SPEED     = 30,
  parameter int CLIMB_SPEED   = 30,
  parameter int JUMP_SPEED    = 180,
  parameter int GRAVITY       = 12,
  parameter int MAX_FALL      = 240,
  parameter int X_MIN         = 36,
  parameter int X_MAX         = 540,
  parameter int COYOTE_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    move_left,
  input  logic                    move_right,
  input  logic                    move_up,
  input  logic                    move_down,
  input  logic                    jump,
  input  logic                    collision_with_ground,
  input  logic                    collision_with_rope,
  input  logic [3:0]              HitEdgeCode,
  output logic signed [POS_W-1:0] topLeftX,
  output logic signed [POS_W-1:0] topLeftY,
  output logic [1:0]              motion_state,
  output logic                    landed
);

  localparam int W = POS_W + FRAC_BITS + 1;

  localparam logic signed [W-1:0] WALK_V   = W'(WALK_SPEED);
  localparam logic signed [W-1:0] AIR_V    = W'(AIR_SPEED);
  localparam logic signed [W-1:0] CLIMB_V  = W'(CLIMB_SPEED);
  localparam logic signed [W-1:0] JUMP_V   = W'(JUMP_SPEED);
  localparam logic signed [W-1:0] GRAV_V   = W'(GRAVITY);
  localparam logic signed [W-1:0] MAX_V    = W'(MAX_FALL);
  localparam logic signed [W-1:0] X_MIN_FP = W'(X_MIN << FRAC_BITS);
  localparam logic signed [W-1:0] X_MAX_FP = W'(X_MAX << FRAC_BITS);
  localparam logic signed [W-1:0] X_RST_FP = W'(INITIAL_X << FRAC_BITS);
  localparam logic signed [W-1:0] Y_RST_FP = W'(INITIAL_Y << FRAC_BITS);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_CLIMB  = 2'd1,
    ST_JUMP   = 2'd2,
    ST_FALL   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic                landed_q, landed_d;
  logic gnd_bot_q, gnd_bot_d, gnd_top_q, gnd_top_d;
  logic gnd_left_q, gnd_left_d, gnd_right_q, gnd_right_d, rope_q, rope_d;

  logic signed [W-1:0] vx_n, vy_n, vy_grav, vx_blk, x_cand;
  logic signed [W-1:0] walk_v, air_v, climb_v;
  logic                take_off, snap_y, coyote_ok;

  // Signed speed from an opposing key pair; both or neither gives zero.
  function automatic logic signed [W-1:0] key_vel(input logic neg, input logic pos,
                                                  input logic signed [W-1:0] speed);
    if (pos && !neg)      return speed;
    else if (neg && !pos) return -speed;
    else                  return '0;
  endfunction

  // Collision latches: the frame pulse starts a fresh frame but still keeps
  // whatever is hitting during that same cycle.
  always_comb begin
    gnd_bot_d   = (startOfFrame ? 1'b0 : gnd_bot_q)   | (collision_with_ground & HitEdgeCode[0]);
    gnd_top_d   = (startOfFrame ? 1'b0 : gnd_top_q)   | (collision_with_ground & HitEdgeCode[2]);
    gnd_left_d  = (startOfFrame ? 1'b0 : gnd_left_q)  | (collision_with_ground & HitEdgeCode[3]);
    gnd_right_d = (startOfFrame ? 1'b0 : gnd_right_q) | (collision_with_ground & HitEdgeCode[1]);
    rope_d      = (startOfFrame ? 1'b0 : rope_q)      | (collision_with_rope & (|HitEdgeCode));
  end

`ifdef COYOTE_TIME_EN
  logic [7:0] coyote_q, coyote_d;
  assign coyote_ok = (coyote_q != 8'd0);

  // Armed only by walking off a ledge; a jump apex never arms it.
  always_comb begin
    coyote_d = coyote_q;
    if (startOfFrame) begin
      if (state_q == ST_GROUND && state_d == ST_FALL)     coyote_d = 8'(COYOTE_FRAMES);
      else if (state_d != ST_FALL)                        coyote_d = 8'd0;
      else if (state_q == ST_FALL && coyote_q != 8'd0)    coyote_d = coyote_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) coyote_q <= 8'd0;
    else       coyote_q <= coyote_d;
  end
`else
  assign coyote_ok = 1'b0;
`endif

  // Next-state and next-velocity. Inside each state the ground checks come
  // first, then the rope, then a takeoff, then gravity.
  always_comb begin
    state_d  = state_q;
    vx_n     = vx_q;
    vy_n     = vy_q;
    landed_d = 1'b0;
    snap_y   = 1'b0;
    take_off = 1'b0;
    vy_grav  = vy_q + GRAV_V;
    walk_v   = key_vel(move_left, move_right, WALK_V);
    air_v    = key_vel(move_left, move_right, AIR_V);
    climb_v  = key_vel(move_up, move_down, CLIMB_V);
    if (startOfFrame) begin
      unique case (state_q)
        ST_GROUND: begin
          if (!gnd_bot_q) begin
            state_d = ST_FALL; vx_n = air_v; vy_n = '0;
          end else if (rope_q && (move_up ^ move_down)) begin
            state_d = ST_CLIMB; vx_n = '0; vy_n = climb_v;
          end else if (jump) begin
            take_off = 1'b1;
          end else begin
            vx_n = walk_v; vy_n = '0;
          end
        end
        ST_CLIMB: begin
          if (gnd_bot_q && move_down) begin
            state_d = ST_GROUND; vx_n = '0; vy_n = '0;
          end else if (!rope_q) begin
            state_d = ST_FALL; vx_n = '0; vy_n = '0;
          end else if (jump) begin
            take_off = 1'b1;
          end else begin
            vx_n = '0; vy_n = climb_v;
          end
        end
        ST_JUMP: begin
          if (gnd_top_q) begin
            state_d = ST_FALL; vy_n = '0;
          end else if (rope_q && (move_up | move_down)) begin
            state_d = ST_CLIMB; vx_n = '0; vy_n = climb_v;
          end else begin
            vy_n = vy_grav;
            if (!vy_grav[W-1]) state_d = ST_FALL;
          end
        end
        default: begin  // ST_FALL
          if (gnd_bot_q) begin
            state_d = ST_GROUND; vx_n = '0; vy_n = '0; snap_y = 1'b1; landed_d = 1'b1;
          end else if (rope_q && (move_up | move_down)) begin
            state_d = ST_CLIMB; vx_n = '0; vy_n = climb_v;
          end else if (jump && coyote_ok) begin
            take_off = 1'b1;
          end else begin
            vy_n = (vy_grav > MAX_V) ? MAX_V : vy_grav;
          end
        end
      endcase
      if (take_off) begin
        state_d = ST_JUMP; vx_n = air_v; vy_n = -JUMP_V;
      end
    end
  end

  // Side blocking, X clamp and position integration with the new velocity.
  always_comb begin
    vx_blk = vx_n;
    if (gnd_left_q && vx_n[W-1])                     vx_blk = '0;
    if (gnd_right_q && !vx_n[W-1] && vx_n != '0)     vx_blk = '0;
    x_cand = x_q + vx_blk;
    x_d  = x_q;
    y_d  = y_q;
    vx_d = vx_q;
    vy_d = vy_q;
    if (startOfFrame) begin
      vx_d = vx_blk;
      vy_d = vy_n;
      x_d  = x_cand;
      y_d  = y_q + vy_n;
      if (x_cand < X_MIN_FP || x_cand > X_MAX_FP) begin
        x_d = (x_cand < X_MIN_FP) ? X_MIN_FP : X_MAX_FP;
        // On the ground the walk speed survives so the key feel is unchanged.
        if (state_d == ST_JUMP || state_d == ST_FALL) vx_d = '0;
      end
      if (snap_y) y_d[FRAC_BITS-1:0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FALL;
      x_q         <= X_RST_FP;
      y_q         <= Y_RST_FP;
      vx_q        <= '0;
      vy_q        <= '0;
      landed_q    <= 1'b0;
      gnd_bot_q   <= 1'b0;
      gnd_top_q   <= 1'b0;
      gnd_left_q  <= 1'b0;
      gnd_right_q <= 1'b0;
      rope_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      landed_q    <= landed_d;
      gnd_bot_q   <= gnd_bot_d;
      gnd_top_q   <= gnd_top_d;
      gnd_left_q  <= gnd_left_d;
      gnd_right_q <= gnd_right_d;
      rope_q      <= rope_d;
    end
  end

  // Outputs: floor of the fixed-point position is just the integer slice.
  always_comb begin
    topLeftX     = x_q[FRAC_BITS +: POS_W];
    topLeftY     = y_q[FRAC_BITS +: POS_W];
    motion_state = state_q;
    landed       = landed_q;
  end

endmodule

// File: tb/tb_sprite_physics_mover.sv
// tb_sprite_physics_mover
// Frame-by-frame bench for sprite_physics_mover: each frame call pushes the
// expected {landed, state, X, Y} onto exp_q, drives keys and collisions,
// pulses startOfFrame and pops/compares once the DUT has updated.
module tb_sprite_physics_mover;

  localparam int EW = 25;
  localparam logic [1:0] ST_GROUND = 2'd0, ST_CLIMB = 2'd1, ST_JUMP = 2'd2, ST_FALL = 2'd3;
  // keys = {left, right, up, down, jump}
  localparam logic [4:0] K_NONE = 5'b00000, K_LEFT = 5'b10000, K_RIGHT = 5'b01000,
                         K_UP = 5'b00100, K_JUMP = 5'b00001;

  logic clk = 1'b0;
  logic reset, startOfFrame;
  logic move_left, move_right, move_up, move_down, jump;
  logic collision_with_ground, collision_with_rope;
  logic [3:0] HitEdgeCode;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0] motion_state;
  logic landed;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int ex, ey, evy;
  logic [1:0] est;

  sprite_physics_mover dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .move_left(move_left), .move_right(move_right), .move_up(move_up),
    .move_down(move_down), .jump(jump),
    .collision_with_ground(collision_with_ground),
    .collision_with_rope(collision_with_rope), .HitEdgeCode(HitEdgeCode),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .motion_state(motion_state), .landed(landed)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Driver: collisions are shown between frames and removed on the frame
  // cycle so each frame's latches hold only that frame's hits.
  task automatic frame(input string tag, input logic [4:0] keys, input logic gnd,
                       input logic rope, input logic [3:0] hec, input logic [1:0] e_st,
                       input int e_x, input int e_y, input logic e_land);
    logic [EW-1:0] e;
    logic [10:0] ex11, ey11;
    ex11 = 11'(e_x >>> 6);
    ey11 = 11'(e_y >>> 6);
    exp_q.push_back({e_land, e_st, ex11, ey11});
    @(negedge clk);
    {move_left, move_right, move_up, move_down, jump} = keys;
    collision_with_ground = gnd;
    collision_with_rope   = rope;
    HitEdgeCode           = hec;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    collision_with_ground = 1'b0;
    collision_with_rope   = 1'b0;
    HitEdgeCode           = 4'b0000;
    startOfFrame          = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_landed"}, landed, e[24]);
    check({tag, "_state"}, motion_state, e[23:22]);
    check({tag, "_x"}, topLeftX[10:0], e[21:11]);
    check({tag, "_y"}, topLeftY[10:0], e[10:0]);
  endtask

  task automatic land(input string tag);
    ey  = ey & ~63;
    evy = 0;
    frame(tag, K_NONE, 1'b1, 1'b0, 4'b0001, ST_GROUND, ex, ey, 1'b1);
  endtask

  // Takeoff from the ground plus the 15 frames up to the apex.
  task automatic jump_arc(input string tag);
    evy = -180;
    ey += evy;
    frame({tag, "_takeoff"}, K_JUMP, 1'b1, 1'b0, 4'b0001, ST_JUMP, ex, ey, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      evy += 12;
      ey  += evy;
      frame(tag, K_NONE, 1'b0, 1'b0, 4'b0000, (evy >= 0) ? ST_FALL : ST_JUMP, ex, ey, 1'b0);
    end
  endtask

  task automatic fall_frame(input string tag, input logic [4:0] keys);
    evy = (evy + 12 > 240) ? 240 : evy + 12;
    ey += evy;
    frame(tag, keys, 1'b0, 1'b0, 4'b0000, ST_FALL, ex, ey, 1'b0);
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0;
    {move_left, move_right, move_up, move_down, jump} = K_NONE;
    collision_with_ground = 1'b0; collision_with_rope = 1'b0; HitEdgeCode = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_x", topLeftX, 280);
    check("rst_y", topLeftY, 185);
    check("rst_state", motion_state, ST_FALL);
    check("rst_landed", landed, 0);
    reset = 1'b0;
    ex = 280 * 64; ey = 185 * 64; evy = 0;

    // Settle onto the ground, then walk right for 32 frames.
    land("land0");
    for (int i = 0; i < 32; i++) begin
      ex += 30;
      frame("walk", K_RIGHT, 1'b1, 1'b0, 4'b0001, ST_GROUND, ex, ey, 1'b0);
    end
    check("walk_end_x", topLeftX, 295);

    // Jump arc to the apex.
    jump_arc("arc1");
    check("apex_y", topLeftY, 162);

    // Free fall to terminal speed, then land with a one-cycle pulse.
    for (int n = 0; n < 25; n++) fall_frame("fall", K_NONE);
    land("land1");
    @(negedge clk);
    check("landed_width", landed, 0);

    // A second arc from the snapped Y exposes leftover fraction bits.
    jump_arc("arc2");
    land("land2");

    // Climb the rope for 4 frames, then lose the rope.
    for (int i = 0; i < 4; i++) begin
      ey -= 30;
      frame("climb", K_UP, 1'b1, 1'b1, 4'b0001, ST_CLIMB, ex, ey, 1'b0);
    end
    frame("rope_drop", K_UP, 1'b0, 1'b0, 4'b0000, ST_FALL, ex, ey, 1'b0);
    land("land3");

    // Walk into the right clamp and push against it.
    for (int i = 0; i < 526; i++) begin
      ex = (ex + 30 > 540 * 64) ? 540 * 64 : ex + 30;
      frame("walk_r", K_RIGHT, 1'b1, 1'b0, 4'b0001, ST_GROUND, ex, ey, 1'b0);
    end
    check("clamp_x", topLeftX, 540);
    // Left wall blocks leftward motion; without it the sprite moves.
    for (int i = 0; i < 3; i++)
      frame("blk_left", K_LEFT, 1'b1, 1'b0, 4'b1001, ST_GROUND, ex, ey, 1'b0);
    ex -= 30;
    frame("walk_l", K_LEFT, 1'b1, 1'b0, 4'b0001, ST_GROUND, ex, ey, 1'b0);

    // Walk off a ledge, jump on the 3rd falling frame.
    evy = 0;
    frame("ledge1", K_NONE, 1'b0, 1'b0, 4'b0000, ST_FALL, ex, ey, 1'b0);
    fall_frame("coy_a1", K_NONE);
    fall_frame("coy_a2", K_NONE);
`ifdef COYOTE_TIME_EN
    evy = -180; ey += evy; est = ST_JUMP;
`else
    evy += 12; ey += evy; est = ST_FALL;
`endif
    frame("coy_jump3", K_JUMP, 1'b0, 1'b0, 4'b0000, est, ex, ey, 1'b0);
    // Head and feet both hit: JUMP turns to FALL, FALL lands.
`ifdef COYOTE_TIME_EN
    evy = 0;
    frame("coy_bump", K_NONE, 1'b1, 1'b0, 4'b0101, ST_FALL, ex, ey, 1'b0);
    land("coy_land");
`else
    land("coy_land");
    frame("coy_stand", K_NONE, 1'b1, 1'b0, 4'b0001, ST_GROUND, ex, ey, 1'b0);
`endif

    // Walk off again; a jump on the 5th falling frame is too late.
    evy = 0;
    frame("ledge2", K_NONE, 1'b0, 1'b0, 4'b0000, ST_FALL, ex, ey, 1'b0);
    for (int i = 0; i < 4; i++) fall_frame("coy_b", K_NONE);
    fall_frame("coy_jump5", K_JUMP);
    land("land4");

    // Reset in the middle of a jump, with a ground hit pending in the latch.
    evy = -180; ey += evy;
    frame("rj_takeoff", K_JUMP, 1'b1, 1'b0, 4'b0001, ST_JUMP, ex, ey, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      evy += 12; ey += evy;
      frame("rj_rise", K_NONE, 1'b0, 1'b0, 4'b0000, ST_JUMP, ex, ey, 1'b0);
    end
    @(negedge clk);
    collision_with_ground = 1'b1; HitEdgeCode = 4'b0001;
    @(negedge clk);
    collision_with_ground = 1'b0; HitEdgeCode = 4'b0000; reset = 1'b1;
    @(negedge clk);
    check("rst2_x", topLeftX, 280);
    check("rst2_y", topLeftY, 185);
    check("rst2_state", motion_state, ST_FALL);
    check("rst2_landed", landed, 0);
    reset = 1'b0;
    ex = 280 * 64; ey = 185 * 64; evy = 0;
    fall_frame("post_rst", K_NONE);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_physics_mover.md
Name: sprite_physics_mover

Overview:
Parametrised successor of the monkey mover. It is a per-sprite motion engine with an explicit GROUND/CLIMB/JUMP/FALL state machine, signed fixed-point velocity, gravity with terminal speed, and per-frame latched collision flags. It sits between the key decoder and the drawing/collision blocks, and it updates once per startOfFrame. It is reusable for the player and for enemy sprites through its parameters.

Parameters:
INITIAL_X, 280, reset X in pixels
INITIAL_Y, 185, reset Y in pixels
POS_W, 11, width of the pixel-position outputs
FRAC_BITS, 6, fixed-point fraction bits (multiplier 2^FRAC_BITS)
WALK_SPEED, 30, ground X speed in fixed-point units per frame
AIR_SPEED, 30, X speed held through a jump or fall
CLIMB_SPEED, 30, rope Y speed per frame
JUMP_SPEED, 180, initial upward speed at takeoff
GRAVITY, 12, Y speed added per frame while airborne
MAX_FALL, 240, downward speed cap
X_MIN, 36, left clamp in pixels
X_MAX, 540, right clamp in pixels
COYOTE_FRAMES, 4, grace frames (used only when COYOTE_TIME_EN is defined)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per frame
move_left, move_right, move_up, move_down, jump  in  1 each  key levels
collision_with_ground  in  1  per-pixel ground hit
collision_with_rope  in  1  per-pixel rope hit
HitEdgeCode  in  4  hit edge: [3] left, [2] top, [1] right, [0] bottom
topLeftX  out  POS_W signed  pixel X
topLeftY  out  POS_W signed  pixel Y
motion_state  out  2  GROUND=0, CLIMB=1, JUMP=2, FALL=3
landed  out  1  one-cycle pulse on a FALL-to-GROUND transition

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: X_fp=INITIAL_X<<FRAC_BITS, Y_fp=INITIAL_Y<<FRAC_BITS, vx=vy=0, motion_state=FALL, landed=0, all latches cleared.
- Internal positions and velocities are signed, POS_W+FRAC_BITS+1 bits wide.
- topLeftX = X_fp>>>FRAC_BITS and topLeftY = Y_fp>>>FRAC_BITS (arithmetic shift, floor).
- Collision latches: every cycle, gnd_bot, gnd_top, gnd_left, gnd_right and rope are ORed in from the collision inputs and HitEdgeCode. Rope is set on any HitEdgeCode bit.
- On a cycle with startOfFrame=1:
  - The FSM, velocity and position all update from the latched flags.
  - The latches are cleared, then that cycle's inputs are ORed into the new frame's latches.
  - Position update uses next velocity: pos <= pos + v_next.
- GROUND state:
  - jump -> JUMP, vy=-JUMP_SPEED, vx=±AIR_SPEED per the left/right key (0 if both or neither).
  - rope and (up xor down) -> CLIMB.
  - !gnd_bot -> FALL with vy=0.
  - Otherwise vx = ±WALK_SPEED per key; both keys pressed -> 0.
- CLIMB state:
  - vx=0; vy = -CLIMB_SPEED on up, +CLIMB_SPEED on down, 0 if both or neither.
  - !rope -> FALL with vy=0.
  - jump -> JUMP (same takeoff rule as GROUND).
  - gnd_bot and down -> GROUND with vy=0.
- JUMP state:
  - vy_next = vy + GRAVITY.
  - vy_next >= 0 -> FALL.
  - gnd_top -> vy=0 and FALL.
  - rope and (up|down) -> CLIMB with vx=0.
- FALL state:
  - vy_next = min(vy+GRAVITY, MAX_FALL).
  - gnd_bot -> GROUND: vy=0, Y fraction bits cleared, landed=1 for that cycle only.
  - rope and (up|down) -> CLIMB.
- Priority within a state: ground transitions first, then rope, then jump, then gravity.
- Side blocking: gnd_left suppresses negative vx; gnd_right suppresses positive vx; the suppressed component is forced to 0 in every state.
- X clamp: the result is clamped to [X_MIN, X_MAX]<<FRAC_BITS. At a clamp, vx is zeroed only in air states.
- Outside startOfFrame cycles, position, velocity and state hold.
- Reset asserted mid-jump returns to the reset values on the next edge; latches are cleared.

Optional Feature:
COYOTE_TIME_EN:
- Defined: a counter loads COYOTE_FRAMES on GROUND->FALL (not on a JUMP apex) and decrements each frame. jump in FALL with counter>0 performs a normal takeoff and zeroes the counter.
- Undefined: the counter is absent, and jump is ignored in FALL.

Test Plan:
1. Reset, gnd_bot latched every frame, move_right for 32 frames -> GROUND held, topLeftX 280->295, topLeftY stays 185.
2. GROUND at Y=185, jump for one frame -> vy=-180, JUMP for 14 more frames, FALL on the 15th frame after takeoff with topLeftY=162.
3. FALL with no collisions for 25 frames -> vy saturates at 240 by frame 20 and stays 240; then gnd_bot -> GROUND, landed pulses for exactly one cycle, Y fraction bits = 0.
4. Rope latched, move_up held 4 frames -> CLIMB, Y_fp decreases by 120 total, topLeftX unchanged. Drop rope -> FALL next frame.
5. GROUND at X=540 with move_right -> X stays at 540. move_left with gnd_left latched -> no movement.
6. With COYOTE_TIME_EN: walk off a ledge, jump on the 3rd FALL frame -> JUMP with vy=-180. Jump on the 5th FALL frame -> remains FALL. Without the macro, both jumps are ignored.
